// File: rtl/intr_prio_cfg_seq_if.sv
// rtl/intr_prio_cfg_seq_if.sv - APB-style bus between the priority sequencer and the interrupt controller
interface intr_prio_cfg_seq_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 4
);
    logic [ADDR_WIDTH-1:0] paddr;
    logic                  pwrite;
    logic [DATA_WIDTH-1:0] pwdata;
    logic                  penable;
    logic [DATA_WIDTH-1:0] prdata;
    logic                  pready;
    logic                  perror;

    modport master (output paddr, pwrite, pwdata, penable, input prdata, pready, perror);
    modport slave  (input paddr, pwrite, pwdata, penable, output prdata, pready, perror);
endinterface

// File: rtl/intr_prio_cfg_seq.sv
// rtl/intr_prio_cfg_seq.sv - programs per-peripheral interrupt priorities over APB
// Optional readback verify pass enabled by PRIO_VERIFY_EN.
module intr_prio_cfg_seq #(
    parameter int NUM_PERIPHERALS = 16,
    parameter int TIMEOUT_CYCLES  = 64,
    parameter int ADDR_WIDTH      = $clog2(NUM_PERIPHERALS),
    parameter int DATA_WIDTH      = $clog2(NUM_PERIPHERALS)
) (
    input  logic                  pclk,
    input  logic                  prst,
    input  logic                  start,
    input  logic [1:0]            mode,
    input  logic                  tbl_we,
    input  logic [ADDR_WIDTH-1:0] tbl_addr,
    input  logic [DATA_WIDTH-1:0] tbl_wdata,
    intr_prio_cfg_seq_if.master   apb,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [2:0]            err_code,
    output logic [ADDR_WIDTH-1:0] err_addr
);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_PERIPHERALS - 1);
    localparam logic [TW-1:0]         TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_W_GAP,
        S_W_ACC,
`ifdef PRIO_VERIFY_EN
        S_R_GAP,
        S_R_ACC,
`endif
        S_DONE,
        S_ERR
    } state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] idx;
    logic [TW-1:0]         tcnt;
    logic [1:0]            mode_q;
    logic [NUM_PERIPHERALS-1:0] seen;
    logic [DATA_WIDTH-1:0] tbl [NUM_PERIPHERALS];

    logic                  idx_clr, idx_inc, tcnt_clr, tcnt_inc, seen_set, start_acc, err_set;
    logic [2:0]            err_code_nxt;
    logic [DATA_WIDTH-1:0] pat;
    logic [ADDR_WIDTH-1:0] bus_addr;
    logic [DATA_WIDTH-1:0] bus_wdata;
    logic                  bus_write, bus_enable;

    // Priority value for the current index under the latched pattern.
    always_comb begin
        case (mode_q)
            2'b01:   pat = DATA_WIDTH'(LAST_IDX - idx);
            2'b10:   pat = tbl[idx];
            default: pat = DATA_WIDTH'(idx);
        endcase
    end

    always_comb begin
        state_nxt    = state;
        idx_clr      = 1'b0;
        idx_inc      = 1'b0;
        tcnt_clr     = 1'b0;
        tcnt_inc     = 1'b0;
        seen_set     = 1'b0;
        start_acc    = 1'b0;
        err_set      = 1'b0;
        err_code_nxt = 3'b000;
        bus_addr     = '0;
        bus_wdata    = '0;
        bus_write    = 1'b0;
        bus_enable   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    start_acc = 1'b1;
                    idx_clr   = 1'b1;
                    state_nxt = (mode == 2'b10) ? S_CHECK : S_W_GAP;
                end
            end
            S_CHECK: begin
                if (seen[tbl[idx]]) begin
                    err_set      = 1'b1;
                    err_code_nxt = 3'b001;
                    state_nxt    = S_ERR;
                end else begin
                    seen_set = 1'b1;
                    if (idx == LAST_IDX) begin
                        idx_clr   = 1'b1;
                        state_nxt = S_W_GAP;
                    end else begin
                        idx_inc = 1'b1;
                    end
                end
            end
            S_W_GAP: begin
                bus_addr  = idx;
                bus_wdata = pat;
                bus_write = 1'b1;
                tcnt_clr  = 1'b1;
                state_nxt = S_W_ACC;
            end
            S_W_ACC: begin
                bus_addr   = idx;
                bus_wdata  = pat;
                bus_write  = 1'b1;
                bus_enable = 1'b1;
                if (apb.pready) begin
                    if (apb.perror) begin
                        err_set      = 1'b1;
                        err_code_nxt = 3'b010;
                        state_nxt    = S_ERR;
                    end else if (idx == LAST_IDX) begin
`ifdef PRIO_VERIFY_EN
                        idx_clr   = 1'b1;
                        state_nxt = S_R_GAP;
`else
                        state_nxt = S_DONE;
`endif
                    end else begin
                        idx_inc   = 1'b1;
                        state_nxt = S_W_GAP;
                    end
                end else if (tcnt == TMO_LAST) begin
                    err_set      = 1'b1;
                    err_code_nxt = 3'b011;
                    state_nxt    = S_ERR;
                end else begin
                    tcnt_inc = 1'b1;
                end
            end
`ifdef PRIO_VERIFY_EN
            S_R_GAP: begin
                bus_addr  = idx;
                tcnt_clr  = 1'b1;
                state_nxt = S_R_ACC;
            end
            S_R_ACC: begin
                bus_addr   = idx;
                bus_enable = 1'b1;
                if (apb.pready) begin
                    if (apb.perror) begin
                        err_set      = 1'b1;
                        err_code_nxt = 3'b010;
                        state_nxt    = S_ERR;
                    end else if (apb.prdata != pat) begin
                        err_set      = 1'b1;
                        err_code_nxt = 3'b100;
                        state_nxt    = S_ERR;
                    end else if (idx == LAST_IDX) begin
                        state_nxt = S_DONE;
                    end else begin
                        idx_inc   = 1'b1;
                        state_nxt = S_R_GAP;
                    end
                end else if (tcnt == TMO_LAST) begin
                    err_set      = 1'b1;
                    err_code_nxt = 3'b011;
                    state_nxt    = S_ERR;
                end else begin
                    tcnt_inc = 1'b1;
                end
            end
`endif
            S_DONE:  state_nxt = S_IDLE;
            S_ERR:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (!prst) begin
            state    <= S_IDLE;
            idx      <= '0;
            tcnt     <= '0;
            mode_q   <= 2'b00;
            seen     <= '0;
            error    <= 1'b0;
            err_code <= 3'b000;
            err_addr <= '0;
            for (int i = 0; i < NUM_PERIPHERALS; i++) tbl[i] <= DATA_WIDTH'(i);
        end else begin
            state <= state_nxt;
            if (idx_clr)      idx <= '0;
            else if (idx_inc) idx <= idx + 1'b1;
            if (tcnt_clr)      tcnt <= '0;
            else if (tcnt_inc) tcnt <= tcnt + 1'b1;
            if (start_acc) begin
                mode_q   <= mode;
                seen     <= '0;
                error    <= 1'b0;
                err_code <= 3'b000;
                err_addr <= '0;
            end else if (seen_set) begin
                seen[tbl[idx]] <= 1'b1;
            end
            if (err_set) begin
                error    <= 1'b1;
                err_code <= err_code_nxt;
                err_addr <= idx;
            end
            if (state == S_IDLE && tbl_we) tbl[tbl_addr] <= tbl_wdata;
        end
    end

    assign busy        = !(state inside {S_IDLE, S_DONE, S_ERR});
    assign done        = (state == S_DONE);
    assign apb.paddr   = bus_addr;
    assign apb.pwdata  = bus_wdata;
    assign apb.pwrite  = bus_write;
    assign apb.penable = bus_enable;

`ifndef PRIO_VERIFY_EN
    logic unused_prdata;
    assign unused_prdata = ^apb.prdata;
`endif
endmodule

// File: tb/tb_intr_prio_cfg_seq.sv
// tb/tb_intr_prio_cfg_seq.sv - directed self-checking bench for intr_prio_cfg_seq
module tb_intr_prio_cfg_seq;
    localparam int N  = 16;
    localparam int AW = 4;
`ifdef PRIO_VERIFY_EN
    localparam int LAT_ASC = 65;
    localparam int LAT_W3  = 161;
    localparam int LAT_TBL = 81;
    localparam int RD_RUN  = 16;
`else
    localparam int LAT_ASC = 33;
    localparam int LAT_W3  = 81;
    localparam int LAT_TBL = 49;
    localparam int RD_RUN  = 0;
`endif

    logic          pclk, prst, start, tbl_we, busy, done, error;
    logic [1:0]    mode;
    logic [AW-1:0] tbl_addr, tbl_wdata, err_addr;
    logic [2:0]    err_code;

    intr_prio_cfg_seq_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(AW)) apb ();

    intr_prio_cfg_seq #(.NUM_PERIPHERALS(N), .TIMEOUT_CYCLES(64)) dut (
        .pclk(pclk), .prst(prst), .start(start), .mode(mode),
        .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_wdata(tbl_wdata),
        .apb(apb.master), .busy(busy), .done(done), .error(error),
        .err_code(err_code), .err_addr(err_addr)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Slave model: configurable waits, error/hang/bad-readback index, transfer log.
    int waits = 0, perr_idx = -1, hang_idx = -1, bad_rd_idx = -1;
    int wr_addr[$];
    int wr_data[$];
    int rd_cnt = 0, acc_total = 0, stable_err = 0, pen_err = 0, last_burst = 0, acc_cnt = 0;
    bit prev_rdy = 0;
    logic [AW-1:0] a0, d0;
    logic [AW-1:0] mem [N];

    always @(negedge pclk) begin : slave
        bit rdy;
        rdy = 1'b0;
        if (!prst) begin
            apb.pready = 1'b0; apb.perror = 1'b0; apb.prdata = '0;
            acc_cnt = 0; prev_rdy = 0;
        end else begin
            if (prev_rdy && apb.penable) pen_err++;
            if (apb.penable) begin
                if (acc_cnt == 0) begin a0 = apb.paddr; d0 = apb.pwdata; end
                else if (apb.paddr != a0 || apb.pwdata != d0) stable_err++;
                acc_cnt++; acc_total++;
                rdy = (int'(apb.paddr) != hang_idx) && (acc_cnt > waits);
                apb.perror = rdy && apb.pwrite && (int'(apb.paddr) == perr_idx);
                apb.prdata = mem[apb.paddr] ^ ((int'(apb.paddr) == bad_rd_idx) ? 4'd1 : 4'd0);
                if (rdy && apb.pwrite && !apb.perror) begin
                    mem[apb.paddr] = apb.pwdata;
                    wr_addr.push_back(int'(apb.paddr));
                    wr_data.push_back(int'(apb.pwdata));
                end
                if (rdy && !apb.pwrite) rd_cnt++;
            end else begin
                if (acc_cnt > 0) last_burst = acc_cnt;
                acc_cnt = 0; apb.perror = 1'b0;
            end
            apb.pready = rdy;
            prev_rdy = rdy;
        end
    end

    int b_wr, b_rd, b_pen, b_acc, b_stab, lat;
    int exp_pat [N];

    task automatic snap();
        b_wr = wr_addr.size(); b_rd = rd_cnt; b_pen = pen_err; b_acc = acc_total; b_stab = stable_err;
    endtask

    task automatic load_tbl(input int a, input int d);
        @(negedge pclk);
        tbl_we = 1'b1; tbl_addr = AW'(a); tbl_wdata = AW'(d);
        @(posedge pclk); #1 tbl_we = 1'b0;
    endtask

    // lat = done cycle after the start edge, 0 on error, -1 on bound expiry.
    task automatic run_seq(input logic [1:0] m, output int l);
        snap();
        @(negedge pclk);
        mode = m; start = 1'b1;
        @(posedge pclk); #1 start = 1'b0;
        l = -1;
        for (int c = 1; c <= 3000; c++) begin
            @(negedge pclk);
            if (c == 1) chk("busy_first_cycle", busy, 1);
            if (done) begin l = c; break; end
            if (error) begin l = 0; break; end
        end
        if (l < 0) chk("seq_bound", 0, 1);
        @(negedge pclk);
    endtask

    task automatic check_writes(input string tag);
        chk({tag, "_count"}, wr_addr.size() - b_wr, N);
        for (int i = 0; i < N; i++) begin
            if (b_wr + i < wr_addr.size()) begin
                chk({tag, "_paddr"}, wr_addr[b_wr + i], i);
                chk({tag, "_pwdata"}, wr_data[b_wr + i], exp_pat[i]);
            end
        end
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_penable"}, apb.penable, 0);
        chk({tag, "_paddr"}, apb.paddr, 0);
        chk({tag, "_pwrite"}, apb.pwrite, 0);
        chk({tag, "_pwdata"}, apb.pwdata, 0);
    endtask

    initial begin
        bit hit;
        prst = 1'b0; start = 1'b0; mode = 2'b00; tbl_we = 1'b0; tbl_addr = '0; tbl_wdata = '0;
        repeat (3) @(posedge pclk);
        #1;
        check_quiet("rst");
        chk("rst_error", error, 0);
        chk("rst_err_code", err_code, 0);
        chk("rst_err_addr", err_addr, 0);
        @(negedge pclk) prst = 1'b1;

        // ascending, zero wait
        for (int i = 0; i < N; i++) exp_pat[i] = i;
        run_seq(2'b00, lat);
        chk("asc_latency", lat, LAT_ASC);
        chk("asc_error", error, 0);
        check_writes("asc");
        chk("asc_reads", rd_cnt - b_rd, RD_RUN);
        chk("asc_penable_gap", pen_err - b_pen, 0);
        check_quiet("asc_after");

        // descending, 3 wait states
        waits = 3;
        for (int i = 0; i < N; i++) exp_pat[i] = N - 1 - i;
        run_seq(2'b01, lat);
        chk("desc_latency", lat, LAT_W3);
        chk("desc_error", error, 0);
        check_writes("desc");
        chk("desc_stable", stable_err - b_stab, 0);
        chk("desc_penable_gap", pen_err - b_pen, 0);
        waits = 0;

        // table permutation
        for (int i = 0; i < N; i++) begin
            exp_pat[i] = (i * 5 + 3) % N;
            load_tbl(i, exp_pat[i]);
        end
        run_seq(2'b10, lat);
        chk("tbl_latency", lat, LAT_TBL);
        chk("tbl_error", error, 0);
        check_writes("tbl");

        // duplicate: entries 5 and 9 both 7
        for (int i = 0; i < N; i++) load_tbl(i, i);
        load_tbl(5, 7); load_tbl(7, 9); load_tbl(9, 7);
        run_seq(2'b10, lat);
        chk("dup_stopped", lat, 0);
        chk("dup_code", err_code, 1);
        chk("dup_addr", err_addr, 9);
        chk("dup_bus_activity", acc_total - b_acc, 0);
        repeat (3) @(negedge pclk);
        chk("dup_error_sticky", error, 1);
        chk("dup_busy", busy, 0);

        // perror on index 4
        perr_idx = 4;
        run_seq(2'b00, lat);
        chk("perr_error", error, 1);
        chk("perr_code", err_code, 2);
        chk("perr_addr", err_addr, 4);
        chk("perr_writes", wr_addr.size() - b_wr, 4);
        chk("perr_penable_drop", pen_err - b_pen, 0);
        perr_idx = -1;

        // hang on index 2
        hang_idx = 2;
        run_seq(2'b00, lat);
        chk("tmo_code", err_code, 3);
        chk("tmo_addr", err_addr, 2);
        chk("tmo_access_cycles", last_burst, 64);
        hang_idx = -1;

`ifdef PRIO_VERIFY_EN
        bad_rd_idx = 11;
        run_seq(2'b00, lat);
        chk("vfy_code", err_code, 4);
        chk("vfy_addr", err_addr, 11);
        chk("vfy_writes", wr_addr.size() - b_wr, N);
        bad_rd_idx = -1;
`endif

        // reset in the middle of the access phase at index 6
        waits = 3;
        @(negedge pclk);
        mode = 2'b00; start = 1'b1;
        @(posedge pclk); #1 start = 1'b0;
        hit = 1'b0;
        for (int c = 0; c < 500; c++) begin
            @(negedge pclk);
            if (apb.penable && apb.paddr == 4'd6) begin hit = 1'b1; break; end
        end
        chk("mid_reached_idx6", int'(hit), 1);
        prst = 1'b0;
        @(posedge pclk); #1;
        check_quiet("mid_rst");
        chk("mid_rst_error", error, 0);
        chk("mid_rst_err_code", err_code, 0);
        @(negedge pclk) prst = 1'b1;
        waits = 0;

        for (int i = 0; i < N; i++) exp_pat[i] = i;
        run_seq(2'b00, lat);
        chk("post_rst_latency", lat, LAT_ASC);
        chk("post_rst_error", error, 0);
        check_writes("post_rst");
        run_seq(2'b10, lat);
        chk("ident_tbl_latency", lat, LAT_TBL);
        check_writes("ident_tbl");

        // reserved mode behaves as ascending
        run_seq(2'b11, lat);
        chk("mode11_latency", lat, LAT_ASC);
        check_writes("mode11");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
